// File: rtl/nunchuk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nunchuk_pkg
// Description : Shared definitions for the Nunchuk report decoder.
//               - FSM state encoding
//               - byte positions within the 6-byte report
//               - dir bit positions
//               - reset values and the all-ones "no controller" pattern
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package nunchuk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_CHECK   = 2'd2
  } state_e;

  localparam int unsigned NUM_BYTES = 6;

  // Byte positions inside the report
  localparam int unsigned JOY_X = 0;
  localparam int unsigned JOY_Y = 1;
  localparam int unsigned ACC_X = 2;
  localparam int unsigned ACC_Y = 3;
  localparam int unsigned ACC_Z = 4;
  localparam int unsigned EXTRA = 5;

  // dir bit positions
  localparam int unsigned DIR_RIGHT = 0;
  localparam int unsigned DIR_LEFT  = 1;
  localparam int unsigned DIR_UP    = 2;
  localparam int unsigned DIR_DOWN  = 3;

  localparam logic [7:0] JOY_RESET = 8'h80;
  localparam logic [9:0] ACC_RESET = 10'h200;
  localparam logic [7:0] ERR_BYTE  = 8'hFF;

  typedef logic [NUM_BYTES-1:0][7:0] frame_t;

  // A disconnected or uninitialised controller reads back all ones
  localparam frame_t ERR_FRAME = {NUM_BYTES{ERR_BYTE}};

endpackage
`default_nettype wire

// File: rtl/nunchuk_dir.sv
`default_nettype none
// ============================================================================
// Module      : nunchuk_dir
// Description : Registered deadzone comparator turning the joystick position
//               into a 4-way direction. A diagonal sets two bits.
// Ports       : clk      - system clock
//               reset_n  - asynchronous active-low reset
//               load_i   - capture a new direction from joy_x_i/joy_y_i
//               joy_x_i  - joystick X position (centre 128)
//               joy_y_i  - joystick Y position (centre 128)
//               dir_o    - {down, up, left, right}, registered
// Revision    : 1.0 - initial release
// ============================================================================
module nunchuk_dir
  import nunchuk_pkg::*;
#(
  parameter int unsigned DEADZONE = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load_i,
  input  logic [7:0] joy_x_i,
  input  logic [7:0] joy_y_i,
  output logic [3:0] dir_o
);

  localparam logic signed [8:0] DZ_POS = 9'(DEADZONE);
  localparam logic signed [8:0] DZ_NEG = -DZ_POS;
  localparam logic signed [8:0] CENTRE = 9'sd128;

  logic signed [8:0] w_dx;
  logic signed [8:0] w_dy;
  logic [3:0]        dir_d;
  logic [3:0]        dir_q;

  // Zero-extended to 9 bits, so the offset from centre cannot overflow
  assign w_dx = $signed({1'b0, joy_x_i}) - CENTRE;
  assign w_dy = $signed({1'b0, joy_y_i}) - CENTRE;

  always_comb begin
    dir_d = dir_q;
    if (load_i) begin
      dir_d            = 4'b0000;
      dir_d[DIR_RIGHT] = (w_dx > DZ_POS);
      dir_d[DIR_LEFT]  = (w_dx < DZ_NEG);
      dir_d[DIR_UP]    = (w_dy > DZ_POS);
      dir_d[DIR_DOWN]  = (w_dy < DZ_NEG);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dir_q <= 4'b0000;
    end else begin
      dir_q <= dir_d;
    end
  end

  assign dir_o = dir_q;

endmodule
`default_nettype wire

// File: rtl/nunchuk_decoder.sv
`default_nettype none
// ============================================================================
// Module      : nunchuk_decoder
// Description : Assembles the 6-byte Wii Nunchuk report from a byte stream,
//               rejects all-ones frames, and decodes good frames into
//               registered joystick, accelerometer, button and direction
//               outputs. Flags a stale controller after TIMEOUT_CYCLES
//               without a good frame.
// Ports       : clk, reset_n        - clock, asynchronous active-low reset
//               byte_valid/byte_data - received byte strobe and data
//               frame_start         - marks byte 0 of a read burst
//               joy_x/joy_y         - joystick position
//               acc_x/acc_y/acc_z   - 10-bit accelerometer axes
//               btn_c/btn_z         - buttons, pressed = 1
//               dir                 - {down, up, left, right}
//               frame_valid         - pulse on output update
//               frame_error         - pulse on a rejected frame
//               stale               - no good frame within the timeout
// Revision    : 1.0 - initial release
// ============================================================================
module nunchuk_decoder
  import nunchuk_pkg::*;
#(
  parameter int unsigned DEADZONE       = 16,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd12_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  input  logic       frame_start,
  output logic [7:0] joy_x,
  output logic [7:0] joy_y,
  output logic [9:0] acc_x,
  output logic [9:0] acc_y,
  output logic [9:0] acc_z,
  output logic       btn_c,
  output logic       btn_z,
  output logic [3:0] dir,
  output logic       frame_valid,
  output logic       frame_error,
  output logic       stale
);

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  frame_t      shadow_q, shadow_d;
  logic [23:0] cnt_q, cnt_d;
  logic        seen_q;

  logic w_start;
  logic w_append;
  logic w_restart;
  logic w_commit;
  logic w_reject;
  logic w_all_ff;

  assign w_all_ff = (shadow_q == ERR_FRAME);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (w_start) state_d = ST_COLLECT;
      ST_COLLECT: if (w_append && (idx_q == 3'(EXTRA))) state_d = ST_CHECK;
      // A frame_start in CHECK opens the next frame straight away
      ST_CHECK:   state_d = w_start ? ST_COLLECT : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    w_start   = byte_valid & frame_start;
    w_append  = 1'b0;
    w_restart = 1'b0;
    w_commit  = 1'b0;
    w_reject  = 1'b0;
    case (state_q)
      ST_COLLECT: begin
        w_append  = byte_valid & ~frame_start;
        w_restart = w_start;
      end
      ST_CHECK: begin
        w_commit = ~w_all_ff;
        w_reject = w_all_ff;
      end
      default: ;
    endcase
  end

  // ---------------- Shadow buffer ----------------
  always_comb begin
    idx_d    = idx_q;
    shadow_d = shadow_q;
    if (w_start) begin
      shadow_d[JOY_X] = byte_data;
      idx_d           = 3'd1;
    end else if (w_append) begin
      for (int unsigned i = 0; i < NUM_BYTES; i++) begin
        if (idx_q == 3'(i)) shadow_d[i] = byte_data;
      end
      idx_d = idx_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q    <= 3'd0;
      shadow_q <= '0;
    end else begin
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
    end
  end

  // ---------------- Decoded outputs ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      joy_x       <= JOY_RESET;
      joy_y       <= JOY_RESET;
      acc_x       <= ACC_RESET;
      acc_y       <= ACC_RESET;
      acc_z       <= ACC_RESET;
      btn_c       <= 1'b0;
      btn_z       <= 1'b0;
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      frame_valid <= w_commit;
      frame_error <= w_reject | w_restart;
      if (w_commit) begin
        joy_x <= shadow_q[JOY_X];
        joy_y <= shadow_q[JOY_Y];
        acc_x <= {shadow_q[ACC_X], shadow_q[EXTRA][3:2]};
        acc_y <= {shadow_q[ACC_Y], shadow_q[EXTRA][5:4]};
        acc_z <= {shadow_q[ACC_Z], shadow_q[EXTRA][7:6]};
        // Nunchuk buttons are active-low on the wire
        btn_z <= ~shadow_q[EXTRA][0];
        btn_c <= ~shadow_q[EXTRA][1];
      end
    end
  end

  nunchuk_dir #(
    .DEADZONE (DEADZONE)
  ) u_dir (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (w_commit),
    .joy_x_i (shadow_q[JOY_X]),
    .joy_y_i (shadow_q[JOY_Y]),
    .dir_o   (dir)
  );

  // ---------------- Stale detection ----------------
  always_comb begin
    cnt_d = cnt_q;
    if (w_commit) begin
      cnt_d = 24'd0;
    end else if (cnt_q != TIMEOUT_CYCLES) begin
      cnt_d = cnt_q + 24'd1;
    end
  end

  // seen_q keeps stale high out of reset until the first good frame,
  // even though the counter itself starts from zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= 24'd0;
      seen_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (w_commit) seen_q <= 1'b1;
    end
  end

  assign stale = ~seen_q | (cnt_q == TIMEOUT_CYCLES);

endmodule
`default_nettype wire

// File: doc/nunchuk_decoder.md
# nunchuk_decoder

Downstream consumer of the I2C master's read data in the Nunchuck project. Assembles the 6-byte Wii Nunchuk report from a byte stream and decodes it into registered values:
- joystick position, with a deadzoned 4-way direction;
- 10-bit accelerometer axes;
- active-high C/Z buttons.

It also flags malformed frames and a stale controller, so the LED renderer and game logic never consume raw, partial or garbage reports.

## Interface
Parameters:
- DEADZONE, 16: joystick half-width around centre 128 that yields no direction (0..127).
- TIMEOUT_CYCLES, 24'd12_000_000: cycles without a good frame before `stale` asserts.

Ports:
- clk  in  1  system clock, single domain.
- reset_n  in  1  asynchronous, active-low reset.
- byte_valid  in  1  one-cycle strobe; `byte_data` holds a received byte.
- byte_data  in  8  received byte.
- frame_start  in  1  qualifies `byte_valid`; marks byte 0 of a read burst.
- joy_x, joy_y  out  8  joystick position; reset 8'h80.
- acc_x, acc_y, acc_z  out  10  accelerometer; reset 10'h200.
- btn_c, btn_z  out  1  pressed = 1; reset 0.
- dir  out  4  bit 0 right, bit 1 left, bit 2 up, bit 3 down; reset 0.
- frame_valid  out  1  one-cycle pulse on output update; reset 0.
- frame_error  out  1  one-cycle pulse on a rejected frame; reset 0.
- stale  out  1  no good frame within the timeout; reset 1.

## Operation
- States: IDLE, COLLECT, CHECK.
- IDLE:
  - `byte_valid & frame_start` stores byte 0, sets idx = 1, goes to COLLECT.
  - `byte_valid` without `frame_start` is ignored, no error.
- COLLECT:
  - Each `byte_valid` stores into shadow[idx] and increments idx.
  - Storing byte 5 goes to CHECK.
  - `byte_valid & frame_start` mid-frame pulses `frame_error`, discards shadow, stores the new byte as byte 0, sets idx = 1 and stays in COLLECT.
- CHECK, one cycle, then IDLE:
  - All six bytes 8'hFF (disconnected or uninitialised): pulse `frame_error`; outputs hold.
  - Otherwise commit to the outputs and pulse `frame_valid`.
- Decode on commit (b0..b5 = shadow):
  - joy_x = b0, joy_y = b1.
  - acc_x = {b2, b5[3:2]}, acc_y = {b3, b5[5:4]}, acc_z = {b4, b5[7:6]}.
  - btn_z = ~b5[0], btn_c = ~b5[1].
- Direction, with dx = {1'b0,joy_x} − 9'd128 and dy = {1'b0,joy_y} − 9'd128 as 9-bit signed (no overflow possible):
  - right = dx > DEADZONE, left = dx < −DEADZONE.
  - up = dy > DEADZONE, down = dy < −DEADZONE.
  - Comparisons are strict; the diagonal sets two bits.
- Stale counter:
  - Cleared on `frame_valid`; otherwise increments, saturating at TIMEOUT_CYCLES.
  - `stale` = (count == TIMEOUT_CYCLES).
  - Errors do not clear it.
- Reset (asserted at any time, including mid-frame): asynchronously clears state to IDLE, idx, shadow and counter; outputs go to their reset values.

## Timing
- Final byte accepted on cycle N → CHECK on N+1 → outputs, `dir`, `frame_valid` or `frame_error` registered and visible on N+2.
- `byte_valid` during CHECK:
  - with `frame_start`: begins a new frame (IDLE rules apply on the same cycle);
  - without: ignored.
- Bytes may arrive back-to-back (every cycle) or with arbitrary gaps; there is no intra-frame timeout.
- `frame_valid` and `frame_error` never assert in the same cycle.
- `stale` deasserts on the same cycle `frame_valid` pulses.
- `stale` reasserts exactly TIMEOUT_CYCLES cycles after the last `frame_valid` with no good frame in between.

## Structure
- A shared package `nunchuk_pkg` holds:
  - byte-index constants (JOY_X = 0 … EXTRA = 5);
  - the `dir` bit positions;
  - the reset constants 8'h80 and 10'h200;
  - the all-ones error pattern.
- Sub-module `nunchuk_dir`: registered deadzone comparator, joy_x/joy_y → dir, parameter DEADZONE. Everything else stays flat.
- Target size 150–250 lines.

## Test plan
- Good frame:
  - stimulus: bytes 8'hF0, 8'h10, 8'h80, 8'h81, 8'hB3, 8'b10_01_11_01 back-to-back, `frame_start` on the first;
  - required, 2 cycles after the last byte: joy_x = F0, joy_y = 10, acc_x = 10'h203, acc_y = 10'h205, acc_z = 10'h2CE, btn_z = 0, btn_c = 1, dir = 4'b1001, one `frame_valid`.
- Deadzone edges, DEADZONE = 16:
  - joy_x = 144 (dx = +16) → dir = 0;
  - joy_x = 145 → right;
  - joy_x = 111 (dx = −17) → left;
  - joy_y = 112 (dy = −16) → none.
- All-FF frame: `frame_error` pulse, no `frame_valid`, previous outputs unchanged.
- Restart mid-frame: `frame_start` on byte 3 → `frame_error` pulse; the following 5 bytes complete the new frame and commit it.
- Stale, TIMEOUT_CYCLES = 100:
  - `stale` = 1 out of reset;
  - clears with the first `frame_valid`;
  - reasserts exactly 100 cycles later.
- Reset mid-frame: drop `reset_n` after 3 bytes → outputs at reset values immediately; the next full frame decodes correctly.
